// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman target feeder: base encodings,
// FSM states and default widths.
package sw_pkg;

  localparam int unsigned DEF_SCORE_WIDTH = 12;
  localparam int unsigned DEF_WORD_BASES  = 16;
  localparam int unsigned DEF_LEN_WIDTH   = 16;
  localparam int unsigned BASE_WIDTH      = 2;

  typedef enum logic [1:0] {
    BASE_T = 2'b00,
    BASE_C = 2'b01,
    BASE_A = 2'b10,
    BASE_G = 2'b11
  } base_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Biased zero score: only the MSB of a w-bit score is set.
  function automatic logic [31:0] zero_score(input int unsigned w);
    return 32'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/sw_base_serializer.sv
// Two-deep target word buffer (cur + prefetch nxt) that emits one 2-bit base
// per consume, LSB-first, with the tgt valid/ready handshake.
module sw_base_serializer
  import sw_pkg::*;
#(
  parameter int unsigned WORD_BASES = DEF_WORD_BASES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    accept_en,
  input  logic                    consume,
  input  logic                    drop,
  input  logic                    tgt_valid,
  output logic                    tgt_ready,
  input  logic [2*WORD_BASES-1:0] tgt_data,
  output logic [BASE_WIDTH-1:0]   base,
  output logic                    base_avail
);

  localparam int unsigned IW = $clog2(WORD_BASES);

  logic [2*WORD_BASES-1:0] cur_q, cur_d, nxt_q, nxt_d;
  logic                    cur_vld_q, cur_vld_d, nxt_vld_q, nxt_vld_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    take, last;

  always_comb begin
    tgt_ready  = accept_en && !nxt_vld_q;
    take       = tgt_valid && tgt_ready;
    base_avail = cur_vld_q;
    base       = cur_q[BASE_WIDTH*idx_q +: BASE_WIDTH];
    last       = consume && cur_vld_q && (drop || (idx_q == IW'(WORD_BASES - 1)));

    cur_d     = cur_q;
    cur_vld_d = cur_vld_q;
    nxt_d     = nxt_q;
    nxt_vld_d = nxt_vld_q;
    idx_d     = idx_q;

    // cur is refilled in the same cycle its final base goes out, so a full
    // nxt gives a bubble-free word boundary.
    if (!cur_vld_q || last) begin
      idx_d = '0;
      if (nxt_vld_q) begin
        cur_d     = nxt_q;
        cur_vld_d = 1'b1;
        nxt_vld_d = 1'b0;
      end else if (take) begin
        cur_d     = tgt_data;
        cur_vld_d = 1'b1;
      end else begin
        cur_vld_d = 1'b0;
      end
    end else begin
      if (consume) idx_d = idx_q + IW'(1);
      if (take) begin
        nxt_d     = tgt_data;
        nxt_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q     <= '0;
      cur_vld_q <= 1'b0;
      nxt_q     <= '0;
      nxt_vld_q <= 1'b0;
      idx_q     <= '0;
    end else begin
      cur_q     <= cur_d;
      cur_vld_q <= cur_vld_d;
      nxt_q     <= nxt_d;
      nxt_vld_q <= nxt_vld_d;
      idx_q     <= idx_d;
    end
  end

endmodule

// File: rtl/sw_target_feeder.sv
// Job sequencer for the Smith-Waterman systolic array: streams target bases,
// waits for the selected PE's score and returns it on a valid/ready port.
module sw_target_feeder
  import sw_pkg::*;
#(
  parameter int unsigned SCORE_WIDTH   = DEF_SCORE_WIDTH,
  parameter int unsigned LENGTH        = 128,
  parameter int unsigned SEL_WIDTH     = 8,
  parameter int unsigned WORD_BASES    = DEF_WORD_BASES,
  parameter int unsigned LEN_WIDTH     = DEF_LEN_WIDTH,
  parameter int unsigned DRAIN_TIMEOUT = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2*LENGTH-1:0]     cmd_query,
  input  logic [SEL_WIDTH-1:0]    cmd_qlen,
  input  logic [LEN_WIDTH-1:0]    cmd_tlen,
  input  logic                    tgt_valid,
  output logic                    tgt_ready,
  input  logic [2*WORD_BASES-1:0] tgt_data,
  output logic                    sa_en,
  output logic [1:0]              sa_data,
  output logic [2*LENGTH-1:0]     sa_query,
  output logic [SEL_WIDTH-1:0]    sa_select,
  input  logic [SCORE_WIDTH-1:0]  sa_result,
  input  logic                    sa_vld,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [SCORE_WIDTH-1:0]  res_score,
  output logic                    res_err,
  output logic                    busy
);

  localparam int unsigned CW = $clog2(DRAIN_TIMEOUT + 1);
  localparam int unsigned DW = ((CW > SEL_WIDTH) ? CW : SEL_WIDTH) + 1;
  localparam logic [SCORE_WIDTH-1:0] SCORE_ZERO = SCORE_WIDTH'(zero_score(SCORE_WIDTH));

  state_e                   state_q, state_d;
  logic                     ready_q, ready_d;
  logic [2*LENGTH-1:0]      query_q, query_d;
  logic [SEL_WIDTH-1:0]     select_q, select_d;
  logic [SEL_WIDTH-1:0]     qlen_q, qlen_d;
  logic [LEN_WIDTH-1:0]     remaining_q, remaining_d;
  logic [DW-1:0]            drain_q, drain_d;
  logic [SCORE_WIDTH-1:0]   score_q, score_d;
  logic                     err_q, err_d;

  logic                     cmd_fire, tlen_zero;
  logic                     accept_en, consume, drop, base_avail;
  logic [BASE_WIDTH-1:0]    base;

  sw_base_serializer #(
    .WORD_BASES (WORD_BASES)
  ) u_ser (
    .clk        (clk),
    .rst        (rst),
    .accept_en  (accept_en),
    .consume    (consume),
    .drop       (drop),
    .tgt_valid  (tgt_valid),
    .tgt_ready  (tgt_ready),
    .tgt_data   (tgt_data),
    .base       (base),
    .base_avail (base_avail)
  );

  always_comb begin
    state_d     = state_q;
    ready_d     = 1'b1;
    query_d     = query_q;
    select_d    = select_q;
    qlen_d      = qlen_q;
    remaining_d = remaining_q;
    drain_d     = drain_q;
    score_d     = score_q;
    err_d       = err_q;

    // ready_q holds cmd_ready low through the reset cycle itself.
    cmd_ready = (state_q == ST_IDLE) && ready_q;
    cmd_fire  = cmd_ready && cmd_valid;
    tlen_zero = (cmd_tlen == '0);
    accept_en = (state_q == ST_STREAM) || (cmd_fire && !tlen_zero);
    consume   = 1'b0;
    drop      = 1'b0;
    sa_en     = 1'b0;
    sa_data   = '0;
    res_valid = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          query_d     = cmd_query;
          select_d    = cmd_qlen - SEL_WIDTH'(1);
          qlen_d      = cmd_qlen;
          remaining_d = cmd_tlen;
          err_d       = 1'b0;
          if (tlen_zero) begin
            score_d = SCORE_ZERO;
            state_d = ST_DONE;
          end else begin
            state_d = ST_STREAM;
          end
        end
      end
      ST_STREAM: begin
        if (base_avail) begin
          sa_en       = 1'b1;
          sa_data     = base;
          consume     = 1'b1;
          remaining_d = remaining_q - LEN_WIDTH'(1);
          if (remaining_q == LEN_WIDTH'(1)) begin
            drop    = 1'b1;
            drain_d = '0;
            state_d = ST_DRAIN;
          end
        end else begin
          err_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q + DW'(1);
        if ((drain_q >= DW'(qlen_q)) && sa_vld) begin
          score_d = sa_result;
          state_d = ST_DONE;
        end else if (drain_q == DW'(DRAIN_TIMEOUT)) begin
          score_d = SCORE_ZERO;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign sa_query  = query_q;
  assign sa_select = select_q;
  assign res_score = score_q;
  assign res_err   = err_q;
  assign busy      = (state_q != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b0;
      query_q     <= '0;
      select_q    <= '0;
      qlen_q      <= '0;
      remaining_q <= '0;
      drain_q     <= '0;
      score_q     <= SCORE_ZERO;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      query_q     <= query_d;
      select_q    <= select_d;
      qlen_q      <= qlen_d;
      remaining_q <= remaining_d;
      drain_q     <= drain_d;
      score_q     <= score_d;
      err_q       <= err_d;
    end
  end

endmodule
